// File: rtl/jpeg_block_pingpong_buffer_if.sv
// Block-buffer bus: block load handshake, element stream handshake and
// parallel read-bank view. The producer/consumer environment uses master,
// the buffer itself uses slave.
interface jpeg_block_pingpong_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_DIM  = 8,
  parameter int NUM_BANKS  = 2
);
  localparam int DEPTH = BLOCK_DIM * BLOCK_DIM;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(NUM_BANKS) + 1;
  localparam int BLK_W = DATA_WIDTH * DEPTH;

  logic                  in_valid;
  logic                  in_ready;
  logic [BLK_W-1:0]      in_block;
  logic                  in_zigzag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]      out_index;
  logic                  out_last;
  logic [BLK_W-1:0]      out_block;
  logic                  out_block_valid;
  logic [OCC_W-1:0]      occupancy;

  modport master (
    output in_valid, in_block, in_zigzag, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last,
           out_block, out_block_valid, occupancy
  );

  modport slave (
    input  in_valid, in_block, in_zigzag, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last,
           out_block, out_block_valid, occupancy
  );
endinterface

// File: rtl/jpeg_block_pingpong_buffer.sv
// Ping-pong (circular multi-bank) block store for the JPEG encoder.
// Whole blocks load in one cycle; elements drain one per handshake in
// raster or zigzag order, and the bank at the read pointer is also
// exposed in parallel. All outputs are decoded from registered state only.
module jpeg_block_pingpong_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_DIM  = 8,
  parameter int NUM_BANKS  = 2
) (
  input  logic clock,
  input  logic reset,
  jpeg_block_pingpong_buffer_if.slave bus
);
  localparam int DEPTH = BLOCK_DIM * BLOCK_DIM;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int OCC_W = $clog2(NUM_BANKS) + 1;
  localparam int BLK_W = DATA_WIDTH * DEPTH;
  localparam bit USE_ZZ = (BLOCK_DIM == 8);

  // Builds the zigzag scan table by walking anti-diagonals, alternating
  // direction: even diagonals run bottom-left to top-right.
  function automatic logic [DEPTH*IDX_W-1:0] build_zz_table();
    logic [DEPTH*IDX_W-1:0] tbl;
    int n;
    int row;
    int lo;
    int hi;
    tbl = '0;
    n   = 0;
    for (int s = 0; s < 2 * BLOCK_DIM - 1; s++) begin
      lo = (s < BLOCK_DIM) ? 0 : s - BLOCK_DIM + 1;
      hi = (s < BLOCK_DIM) ? s : BLOCK_DIM - 1;
      for (int j = 0; j <= hi - lo; j++) begin
        row = ((s % 2) == 0) ? hi - j : lo + j;
        tbl[n*IDX_W +: IDX_W] = IDX_W'(row * BLOCK_DIM + (s - row));
        n++;
      end
    end
    return tbl;
  endfunction

  localparam logic [DEPTH*IDX_W-1:0] ZZ_TABLE = build_zz_table();

  // Circular pointer increment across the bank ring.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NUM_BANKS - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic [BLK_W-1:0]     bank_r [NUM_BANKS];
  logic [NUM_BANKS-1:0] zz_tag_r;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [IDX_W-1:0]     k_r;
  logic [OCC_W-1:0]     occ_r;

  logic                  in_ready_s;
  logic                  has_data_s;
  logic                  load_s;
  logic                  xfer_s;
  logic                  last_s;
  logic                  release_s;
  logic [IDX_W-1:0]      addr_s;
  logic [BLK_W-1:0]      rd_block_s;
  logic [DATA_WIDTH-1:0] rd_elem_s;

  // Handshake decode and read-address selection from registered state.
  always_comb begin
    in_ready_s = (occ_r < OCC_W'(NUM_BANKS));
    has_data_s = (occ_r != OCC_W'(0));
    load_s     = bus.in_valid && in_ready_s;
    xfer_s     = has_data_s && bus.out_ready;
    last_s     = (k_r == IDX_W'(DEPTH - 1));
    release_s  = xfer_s && last_s;
    rd_block_s = bank_r[rd_ptr_r];
    if (USE_ZZ && zz_tag_r[rd_ptr_r]) begin
      addr_s = ZZ_TABLE[int'(k_r)*IDX_W +: IDX_W];
    end else begin
      addr_s = k_r;
    end
    rd_elem_s = rd_block_s[(BLK_W - 1) - int'(addr_s) * DATA_WIDTH -: DATA_WIDTH];
  end

  // Bank storage, pointers, element counter and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_r[b] <= '0;
      end
      zz_tag_r <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      k_r      <= '0;
      occ_r    <= '0;
    end else begin
      if (load_s) begin
        bank_r[wr_ptr_r]   <= bus.in_block;
        zz_tag_r[wr_ptr_r] <= bus.in_zigzag;
        wr_ptr_r           <= next_ptr(wr_ptr_r);
      end
      if (xfer_s) begin
        if (last_s) begin
          k_r      <= '0;
          rd_ptr_r <= next_ptr(rd_ptr_r);
        end else begin
          k_r <= k_r + IDX_W'(1);
        end
      end
      case ({load_s, release_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign bus.in_ready        = in_ready_s;
  assign bus.out_valid       = has_data_s;
  assign bus.out_block_valid = has_data_s;
  assign bus.out_data        = rd_elem_s;
  assign bus.out_index       = addr_s;
  assign bus.out_last        = last_s;
  assign bus.out_block       = rd_block_s;
  assign bus.occupancy       = occ_r;
endmodule

// File: tb/tb_jpeg_block_pingpong_buffer.sv
// Scoreboard bench for jpeg_block_pingpong_buffer: the driver pushes the
// expected element stream and block image of every accepted load; a
// negedge monitor checks handshake/occupancy and pops on each transfer.
module tb_jpeg_block_pingpong_buffer;
  localparam int DW = 8;
  localparam int DEPTH = 64;
  localparam int BLK_W = DW * DEPTH;
  localparam int NB = 2;

  localparam int ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef struct {
    logic [7:0] d;
    logic [5:0] idx;
    logic       last;
  } elem_t;

  logic clock;
  logic reset;
  jpeg_block_pingpong_buffer_if #(.DATA_WIDTH(DW), .BLOCK_DIM(8), .NUM_BANKS(NB)) bus ();

  jpeg_block_pingpong_buffer #(.DATA_WIDTH(DW), .BLOCK_DIM(8), .NUM_BANKS(NB)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;
  elem_t exp_q[$];
  logic [BLK_W-1:0] blk_q[$];
  int push_cnt = 0;
  int rel_cnt = 0;
  int pend = 0;
  logic [7:0] cur_blk [64];

  task automatic chk(input string nm, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [BLK_W-1:0] pack_blk();
    logic [BLK_W-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[BLK_W-1-8*i -: 8] = cur_blk[i];
    return v;
  endfunction

  // Drive one cycle of stimulus (called just after a rising edge); if the
  // reference buffer has room, the load is accepted and its expectations queued.
  task automatic issue(input bit v, input bit zz, input bit ordy, output bit acc);
    elem_t e;
    int a;
    acc = v && ((push_cnt - rel_cnt) < NB);
    pend = acc ? 1 : 0;
    if (acc) begin
      push_cnt++;
      blk_q.push_back(pack_blk());
      for (int k = 0; k < DEPTH; k++) begin
        a = zz ? ZZ[k] : k;
        e.d = cur_blk[a];
        e.idx = 6'(a);
        e.last = (k == DEPTH - 1);
        exp_q.push_back(e);
      end
    end
    bus.in_valid = v;
    bus.in_zigzag = zz;
    bus.in_block = pack_blk();
    bus.out_ready = ordy;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    exp_q.delete();
    blk_q.delete();
    push_cnt = 0;
    rel_cnt = 0;
    pend = 0;
    reset = 1'b0;
  endtask

  task automatic idle_checks(input string tag);
    @(negedge clock);
    chk({tag, "_out_block"}, bus.out_block, '0);
    chk({tag, "_out_data"}, {504'd0, bus.out_data}, '0);
    chk({tag, "_out_index"}, {506'd0, bus.out_index}, '0);
    chk({tag, "_out_last"}, {511'd0, bus.out_last}, '0);
    chk({tag, "_in_ready"}, {511'd0, bus.in_ready}, {511'd0, 1'b1});
  endtask

  task automatic drain(input string tag);
    bit acc;
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      issue(1'b0, 1'b0, 1'b1, acc);
      g++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: %0d elements left, required 0", tag, exp_q.size());
    end
  endtask

  // Monitor: compare registered outputs against the reference each negedge.
  initial begin
    int exp_occ;
    elem_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        exp_occ = push_cnt - pend - rel_cnt;
        chk("occupancy", {509'd0, bus.occupancy}, BLK_W'(exp_occ));
        chk("in_ready", {511'd0, bus.in_ready}, BLK_W'(exp_occ < NB));
        chk("out_valid", {511'd0, bus.out_valid}, BLK_W'(exp_occ != 0));
        chk("out_block_valid", {511'd0, bus.out_block_valid}, BLK_W'(exp_occ != 0));
        if (exp_occ != 0 && exp_q.size() != 0) begin
          e = exp_q[0];
          chk("out_block", bus.out_block, blk_q[0]);
          chk("out_data", {504'd0, bus.out_data}, {504'd0, e.d});
          chk("out_index", {506'd0, bus.out_index}, {506'd0, e.idx});
          chk("out_last", {511'd0, bus.out_last}, {511'd0, e.last});
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            if (e.last) begin
              void'(blk_q.pop_front());
              rel_cnt++;
            end
          end
        end
      end
    end
  end

  initial begin
    bit acc;
    int g;
    int loaded;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_zigzag = 1'b0;
    bus.in_block = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) cur_blk[i] = 8'(i);
    do_reset();
    idle_checks("reset");

    // Raster ramp block, then zigzag ramp block, consumer always ready.
    issue(1'b1, 1'b0, 1'b1, acc);
    drain("raster");
    issue(1'b1, 1'b1, 1'b1, acc);
    drain("zigzag");

    // Reset in the middle of a stream, then a fresh block must start at k = 0.
    issue(1'b1, 1'b0, 1'b1, acc);
    repeat (20) issue(1'b0, 1'b0, 1'b1, acc);
    do_reset();
    idle_checks("midreset");
    for (int i = 0; i < DEPTH; i++) cur_blk[i] = 8'(255 - i);
    issue(1'b1, 1'b0, 1'b1, acc);
    drain("after_reset");

    // Backpressure: A and B fill the buffer, C waits for A's release.
    for (int i = 0; i < DEPTH; i++) cur_blk[i] = 8'hAA;
    issue(1'b1, 1'b0, 1'b0, acc);
    for (int i = 0; i < DEPTH; i++) cur_blk[i] = 8'hBB;
    issue(1'b1, 1'b0, 1'b0, acc);
    for (int i = 0; i < DEPTH; i++) cur_blk[i] = 8'hCC;
    repeat (4) issue(1'b1, 1'b0, 1'b0, acc);
    acc = 1'b0;
    g = 0;
    while (!acc && g < 200) begin
      issue(1'b1, 1'b0, 1'b1, acc);
      g++;
    end
    drain("backpressure");

    // Load lands on the same edge as the previous block's final transfer.
    for (int i = 0; i < DEPTH; i++) cur_blk[i] = 8'(i * 3);
    issue(1'b1, 1'b1, 1'b1, acc);
    repeat (63) issue(1'b0, 1'b0, 1'b1, acc);
    for (int i = 0; i < DEPTH; i++) cur_blk[i] = 8'(i ^ 8'h5A);
    issue(1'b1, 1'b0, 1'b1, acc);
    drain("overlap");

    // Random traffic: 100 blocks, random tags, 50% backpressure.
    loaded = 0;
    g = 0;
    while (loaded < 100 && g < 40000) begin
      for (int i = 0; i < DEPTH; i++) cur_blk[i] = 8'($urandom);
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
      if (acc) loaded++;
      g++;
    end
    n_checks++;
    if (loaded < 100) begin
      n_fail++;
      $display("FAIL random_load_timeout: loaded %0d, required 100", loaded);
    end
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
